// File: rtl/video_fetch_fifo_pkg.sv
// Shared definitions for the video fetch path: fetch FSM encoding,
// default frame size and the byte-lane helper used on the FIFO head word.
package video_fetch_fifo_pkg;

    // 640x480 pixels at 1 bpp, packed into 32-bit words.
    localparam int C_FRAME_WORDS_DEFAULT = 9600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // after reset, waiting for the first frame start
        ST_FETCH = 3'd1,   // bus read outstanding, data will be kept
        ST_READY = 3'd2,   // between requests, waiting for FIFO space
        ST_DRAIN = 3'd3,   // bus read outstanding, data will be discarded
        ST_DONE  = 3'd4    // whole frame fetched, waiting for next frame start
    } fetch_state_t;

    // Byte 0 is bits [7:0]; it holds the leftmost pixels of the word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] lane;
        case (idx)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/video_fetch_fifo_fifo.sv
// Synchronous 32-bit wide FIFO with a flush input. The head word is shown
// combinationally from storage so a push into an empty FIFO is visible on
// the cycle after the write.
module fifo_sync_w32 #(
    parameter int C_log2 = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [31:0]       wdata,
    input  logic              pop,
    output logic [31:0]       head,
    output logic [C_log2:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int C_depth = 1 << C_log2;
    localparam logic [C_log2:0] C_full_count = (C_log2 + 1)'(C_depth);

    logic [31:0]       mem [C_depth];
    logic [C_log2-1:0] wr_ptr;
    logic [C_log2-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A write into a full FIFO or a read from an empty one is ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == C_full_count);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo depth; count is one bit wider to tell full from empty.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + C_log2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + C_log2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (C_log2 + 1)'(1);
                2'b01:   count <= count - (C_log2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_fetch_fifo.sv
// Framebuffer fetch engine: reads one frame of 32-bit words over a simple
// strobe/ready bus into a FIFO and hands them to the display stage a byte
// at a time. Bus handshake: addr_strobe rises with a valid addr and both
// stay stable until the cycle data_ready is high; that cycle completes the
// read, and addr_strobe is low for at least one cycle before the next one.
module video_fetch_fifo
    import video_fetch_fifo_pkg::*;
#(
    parameter int C_addr_bits   = 30,
    parameter int C_fifo_log2   = 4,
    parameter int C_frame_words = C_FRAME_WORDS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [C_addr_bits-1:0] base_addr,
    output logic                   addr_strobe,
    output logic [C_addr_bits-1:0] addr,
    input  logic                   data_ready,
    input  logic [31:0]            data_in,
    input  logic                   vga_vsync,
    input  logic                   rd,
    output logic [7:0]             disp_data,
    output logic                   underflow,
    output logic [2:0]             fsm_state
);

    localparam int C_cnt_bits = $clog2(C_frame_words + 1);
    localparam logic [C_cnt_bits-1:0] C_last_word = C_cnt_bits'(C_frame_words - 1);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic                  reinit;
    logic                  push_word;
    logic                  vsync_meta;
    logic                  vsync_sync;
    logic                  vsync_prev;
    logic                  frame_start;
    logic [C_cnt_bits-1:0] word_cnt;
    logic [1:0]            byte_idx;
    logic                  pop_word;
    logic [31:0]           fifo_head;
    logic [C_fifo_log2:0]  fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Two-flop synchronizer plus edge history; idles high (vsync inactive).
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_meta <= 1'b1;
            vsync_sync <= 1'b1;
            vsync_prev <= 1'b1;
        end else begin
            vsync_meta <= vga_vsync;
            vsync_sync <= vsync_meta;
            vsync_prev <= vsync_sync;
        end
    end

    assign frame_start = vsync_prev && !vsync_sync;

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM next state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        reinit     = 1'b0;
        push_word  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (frame_start) begin
                    reinit     = 1'b1;
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (frame_start) begin
                    reinit = 1'b1;
                end else if (!fifo_full) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (frame_start) begin
                    // A read completing in the same cycle is already over,
                    // so there is nothing left to drain.
                    if (data_ready) begin
                        reinit     = 1'b1;
                        state_next = ST_READY;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (data_ready) begin
                    push_word  = 1'b1;
                    state_next = (word_cnt == C_last_word) ? ST_DONE : ST_READY;
                end
            end
            ST_DRAIN: begin
                if (data_ready) begin
                    reinit     = 1'b1;
                    state_next = ST_READY;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address, word count, byte index and sticky underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            underflow <= 1'b0;
        end else if (reinit) begin
            addr      <= base_addr;
            word_cnt  <= '0;
            byte_idx  <= '0;
            underflow <= 1'b0;
        end else begin
            if (push_word) begin
                addr     <= addr + C_addr_bits'(1);
                word_cnt <= word_cnt + C_cnt_bits'(1);
            end
            if (rd) begin
                if (fifo_empty) begin
                    underflow <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    assign pop_word    = rd && !fifo_empty && (byte_idx == 2'd3) && !reinit;
    assign addr_strobe = (state == ST_FETCH) || (state == ST_DRAIN);
    assign disp_data   = fifo_empty ? 8'h00 : byte_lane(fifo_head, byte_idx);
    assign fsm_state   = state;

    fifo_sync_w32 #(
        .C_log2 (C_fifo_log2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (reinit),
        .push  (push_word),
        .wdata (data_in),
        .pop   (pop_word),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Directed bench for video_fetch_fifo with a word scoreboard: words the bus
// model returns are queued and compared byte by byte as the display reads.
module tb_video_fetch_fifo;

    localparam int AW = 30;
    localparam int FW = 20;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] base_addr;
    logic          addr_strobe;
    logic [AW-1:0] addr;
    logic          data_ready;
    logic [31:0]   data_in;
    logic          vga_vsync;
    logic          rd;
    logic [7:0]    disp_data;
    logic          underflow;
    logic [2:0]    fsm_state;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    int            bidx = 0;

    always #5 clk = ~clk;

    video_fetch_fifo #(
        .C_addr_bits   (AW),
        .C_fifo_log2   (4),
        .C_frame_words (FW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .base_addr   (base_addr),
        .addr_strobe (addr_strobe),
        .addr        (addr),
        .data_ready  (data_ready),
        .data_in     (data_in),
        .vga_vsync   (vga_vsync),
        .rd          (rd),
        .disp_data   (disp_data),
        .underflow   (underflow),
        .fsm_state   (fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int n = 0;
        while (addr_strobe !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, addr_strobe}, 32'd1);
    endtask

    // Bus model: answer one request after lat cycles.
    task automatic serve(input logic [AW-1:0] exp_addr, input logic [31:0] word,
                         input int lat, input bit keep);
        wait_strobe("req_strobe", 50);
        chk("req_addr", {2'b00, addr}, {2'b00, exp_addr});
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("strobe_hold", {31'd0, addr_strobe}, 32'd1);
            chk("addr_hold", {2'b00, addr}, {2'b00, exp_addr});
        end
        data_ready = 1'b1;
        data_in    = word;
        tick();
        data_ready = 1'b0;
        data_in    = $urandom;
        if (keep) exp_q.push_back(word);
        chk("strobe_gap", {31'd0, addr_strobe}, 32'd0);
    endtask

    // Display model: compare the current byte against the queue head, then consume it.
    task automatic read_byte(input string tag);
        logic [31:0] w;
        logic [31:0] sh;
        w  = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
        sh = w >> (8 * bidx);
        chk(tag, {24'd0, disp_data}, {24'd0, sh[7:0]});
        rd = 1'b1;
        tick();
        rd = 1'b0;
        bidx = (bidx + 1) % 4;
        if (bidx == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] head;
        reset      = 1'b1;
        base_addr  = '0;
        data_ready = 1'b0;
        data_in    = '0;
        vga_vsync  = 1'b1;
        rd         = 1'b0;
        repeat (3) tick();
        chk("rst_strobe", {31'd0, addr_strobe}, 32'd0);
        chk("rst_addr", {2'b00, addr}, 32'd0);
        chk("rst_disp", {24'd0, disp_data}, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        chk("rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
        reset = 1'b0;
        tick();
        chk("idle_no_strobe", {31'd0, addr_strobe}, 32'd0);

        // Frame 1: sync delay, then fill the FIFO to full.
        base_addr = 30'h100;
        vga_vsync = 1'b0;
        tick();
        tick();
        chk("sync_not_yet", {29'd0, fsm_state}, {29'd0, ST_IDLE});
        tick();
        chk("start_ready", {29'd0, fsm_state}, {29'd0, ST_READY});
        chk("start_no_strobe", {31'd0, addr_strobe}, 32'd0);
        tick();
        chk("first_strobe", {31'd0, addr_strobe}, 32'd1);
        chk("first_addr", {2'b00, addr}, 32'h100);
        vga_vsync = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = (i == 0) ? 32'h4433_2211 : $urandom;
            serve(AW'(32'h100 + i), w, $urandom_range(0, 3), 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_no_strobe", {31'd0, addr_strobe}, 32'd0);
        end

        // Byte order of the head word, then one pop frees one slot.
        chk("byte0_const", {24'd0, disp_data}, 32'h11);
        for (int i = 0; i < 4; i++) read_byte("byte_order");
        head = exp_q[0];
        chk("next_word_b0", {24'd0, disp_data}, {24'd0, head[7:0]});
        serve(30'h110, $urandom, 1, 1'b1);
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 4; i++) read_byte("refill_byte");
            serve(AW'(32'h110 + k), $urandom, $urandom_range(0, 2), 1'b1);
        end
        chk("frame_done", {29'd0, fsm_state}, {29'd0, ST_DONE});
        chk("frame_end_addr", {2'b00, addr}, 32'h100 + FW);

        // Drain the rest; no new requests once the frame is complete.
        while (exp_q.size() > 0) begin
            read_byte("drain_byte");
            chk("done_no_strobe", {31'd0, addr_strobe}, 32'd0);
        end
        chk("empty_disp", {24'd0, disp_data}, 32'd0);
        chk("no_underflow_yet", {31'd0, underflow}, 32'd0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("underflow_set", {31'd0, underflow}, 32'd1);
        chk("underflow_disp", {24'd0, disp_data}, 32'd0);
        tick();
        chk("underflow_sticky", {31'd0, underflow}, 32'd1);

        // Frame 2: clears underflow; then restart with a request outstanding.
        base_addr = 30'h200;
        vga_vsync = 1'b0;
        repeat (3) tick();
        chk("underflow_cleared", {31'd0, underflow}, 32'd0);
        tick();
        chk("f2_strobe", {31'd0, addr_strobe}, 32'd1);
        chk("f2_addr", {2'b00, addr}, 32'h200);
        vga_vsync = 1'b1;
        repeat (3) tick();
        vga_vsync = 1'b0;
        base_addr = 30'h300;
        repeat (3) tick();
        chk("drain_state", {29'd0, fsm_state}, {29'd0, ST_DRAIN});
        chk("drain_strobe", {31'd0, addr_strobe}, 32'd1);
        chk("drain_addr", {2'b00, addr}, 32'h200);
        vga_vsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_hold", {31'd0, addr_strobe}, 32'd1);
        end
        data_ready = 1'b1;
        data_in    = 32'hDEAD_BEEF;
        tick();
        data_ready = 1'b0;
        chk("drain_to_ready", {29'd0, fsm_state}, {29'd0, ST_READY});
        chk("drain_discard", {24'd0, disp_data}, 32'd0);
        chk("drain_gap", {31'd0, addr_strobe}, 32'd0);
        tick();
        chk("restart_strobe", {31'd0, addr_strobe}, 32'd1);
        chk("restart_addr", {2'b00, addr}, 32'h300);

        // Reset in the middle of a fetch with data in the FIFO.
        serve(30'h300, $urandom, 1, 1'b1);
        read_byte("pre_reset_byte");
        wait_strobe("pre_reset_strobe", 10);
        chk("pre_reset_addr", {2'b00, addr}, 32'h301);
        reset = 1'b1;
        tick();
        chk("mid_rst_strobe", {31'd0, addr_strobe}, 32'd0);
        chk("mid_rst_addr", {2'b00, addr}, 32'd0);
        chk("mid_rst_disp", {24'd0, disp_data}, 32'd0);
        chk("mid_rst_underflow", {31'd0, underflow}, 32'd0);
        chk("mid_rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
        exp_q.delete();
        bidx  = 0;
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", {31'd0, addr_strobe}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_fetch_fifo.md
VIDEO_FETCH_FIFO -- requirements
Module: video_fetch_fifo

Interface
REQ-001 Parameters (name, default, meaning); per-port lines follow as name, direction, width, meaning, clock and reset first:
- C_addr_bits, 30, word-address width.
- C_fifo_log2, 4, log2 of FIFO depth in 32-bit words (16).
- C_frame_words, 9600, words fetched per frame (640x480 at 1 bpp).
REQ-002 clk  in  1  CPU clock; the only clock; every register is clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 base_addr  in  C_addr_bits  framebuffer start word address; sampled at each frame start.
REQ-005 addr_strobe  out  1  bus read request.
REQ-006 addr  out  C_addr_bits  bus word address.
REQ-007 data_ready  in  1  bus read completes this cycle.
REQ-008 data_in  in  32  bus read data, valid when data_ready=1.
REQ-009 vga_vsync  in  1  active-low vsync from the display stage, asynchronous to clk.
REQ-010 rd  in  1  one-clk pulse: the display stage consumed the current byte.
REQ-011 disp_data  out  8  current pixel byte; bit0 is the leftmost pixel.
REQ-012 underflow  out  1  sticky: rd arrived while the FIFO was empty.

Function
REQ-013 vga_vsync SHALL pass through a 2-flop synchronizer; the falling edge of the synchronized signal SHALL give a 1-cycle frame_start pulse, 3 clk after the input falls.
REQ-014 Fetch FSM states: IDLE, FETCH (request outstanding), READY (between requests), DRAIN (outstanding request whose data is discarded), DONE.
REQ-015 In IDLE or DONE, frame_start -> flush the FIFO, addr<=base_addr, word count<=0, byte index<=0, underflow<=0, go to READY.
REQ-016 READY: when fill count < 2^C_fifo_log2, assert addr_strobe with the current addr and go to FETCH; otherwise stay in READY.
REQ-017 FETCH: hold addr_strobe and addr stable until data_ready.
REQ-018 FETCH on data_ready: write data_in to the FIFO, addr+1, count+1, deassert addr_strobe; go to DONE if count reaches C_frame_words, else READY.
REQ-019 At most one request is outstanding at a time; addr_strobe SHALL be low for at least 1 cycle between requests.
REQ-020 frame_start during FETCH: go to DRAIN and keep addr_strobe asserted; on data_ready, discard the data, perform the REQ-015 reinit and go to READY.
REQ-021 frame_start in READY: perform the REQ-015 reinit and stay in READY.
REQ-022 disp_data = byte[byte index] of the FIFO head word (byte 0 = data_in[7:0]); it SHALL be 0x00 while the FIFO is empty.
REQ-023 rd with the FIFO non-empty: byte index+1; at index 3, index<=0 and pop the head word.
REQ-024 rd with the FIFO empty: set underflow; FIFO and byte index unchanged.
REQ-025 Simultaneous push and pop: fill count unchanged and both words correct; a push to an empty FIFO is visible on disp_data in the next cycle.
REQ-026 Pointers SHALL wrap modulo depth; fill count SHALL be C_fifo_log2+1 bits; addr increment wraps modulo 2^C_addr_bits.
REQ-027 The FIFO SHALL never be overwritten when full (guaranteed by REQ-016 and REQ-019).

Reset
REQ-028 Reset SHALL be synchronous and active-high and SHALL take priority over all other events.
REQ-029 During reset: state IDLE, addr_strobe=0, addr=0, FIFO empty, byte index 0, disp_data=0x00, underflow=0, synchronizer flops=1 (vsync inactive).
REQ-030 A reset during FETCH SHALL drop addr_strobe in the next cycle.

Structure
REQ-031 FSM state encoding and the default frame-size constant SHALL live in the shared video package.
REQ-032 FIFO storage and pointers SHALL be one sub-module, fifo_sync_w32 (storage, wr/rd pointers, count, full/empty); the FSM, byte lane selection and synchronizer stay in the top level.

Verification
REQ-033 Bench SHALL cover these directed scenarios:
- Reset, then vsync fall with base_addr=0x100 -> first addr_strobe with addr=0x100 after the sync delay; 16 words fetched, then strobe stays low while full.
- Word 0x44332211 in the FIFO, 4 rd pulses -> disp_data 0x11, 0x22, 0x33, 0x44, then the next word's byte 0; one pop.
- rd while empty -> underflow=1, disp_data=0x00; next frame_start clears underflow.
- frame_start with a request outstanding, data_ready 5 cycles later -> data discarded, FIFO empty, next strobe at base_addr.
- C_frame_words=20 -> exactly 20 strobes, addr ends at base+20, state DONE; no further strobes until the next vsync.
- Reset asserted mid-FETCH -> addr_strobe=0 next cycle, all outputs at reset values.
